// File: rtl/fifo_rd_arbiter.sv
// Round-robin read-side arbiter for a bank of dual-clock FIFOs.
// Pops one word per READ/LOAD/SEND pass, bounded bursts per grant.
module fifo_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_MAX  = 4,
  parameter int SRC_W      = $clog2(NUM_REQ)
) (
  input  logic                          rclk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            fifo_empty_bar,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_REQ-1:0]            fifo_re,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]              out_src,
  output logic                          busy
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    LOAD,
    SEND
  } state_t;

  state_t                state;
  logic [SRC_W-1:0]      grant;
  logic [SRC_W-1:0]      last;
  logic [CNT_W-1:0]      burst_cnt;

  logic [SRC_W-1:0]      rr_pick;
  logic                  rr_hit;
  logic [SRC_W-1:0]      cand;
  logic [NUM_REQ-1:0]    pick_oh;
  logic [NUM_REQ-1:0]    grant_oh;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  more;

  // Search starts just after the last served index, so it is tried last.
  always_comb begin
    rr_pick = '0;
    rr_hit  = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = SRC_W'((int'(last) + k) % NUM_REQ);
      if (!rr_hit && fifo_empty_bar[cand]) begin
        rr_hit  = 1'b1;
        rr_pick = cand;
      end
    end
  end

  always_comb begin
    pick_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << rr_pick;
    grant_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;
    grant_data = fifo_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    more       = (burst_cnt < CNT_W'(BURST_MAX)) &&
                 fifo_empty_bar[grant];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fifo_re   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      burst_cnt <= '0;
      grant     <= '0;
      last      <= SRC_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (rr_hit) begin
            grant     <= rr_pick;
            burst_cnt <= '0;
            fifo_re   <= pick_oh;
            state     <= READ;
          end
        end
        READ: begin
          fifo_re   <= '0;
          burst_cnt <= burst_cnt + CNT_W'(1);
          state     <= LOAD;
        end
        LOAD: begin
          out_data  <= grant_data;
          out_src   <= grant;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (more) begin
              fifo_re <= grant_oh;
              state   <= READ;
            end else begin
              last  <= grant;
              state <= IDLE;
            end
          end
        end
        default: begin
          fifo_re <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: two instances (BURST_MAX 4 and 1)
// fed by behavioral FIFO models, checked against a scoreboard.
module tb_fifo_rd_arbiter;

  logic rclk = 1'b0;
  logic reset = 1'b1;
  always #5 rclk = ~rclk;

  logic [31:0]  mem [2][4][16];
  int           wp [2][4];
  int           rp [2][4];
  logic [31:0]  dout [2][4];
  logic [3:0]   eb [2];
  logic [127:0] fd [2];
  logic [3:0]   re [2];
  logic         ov [2];
  logic         rdy [2];
  logic [31:0]  od [2];
  logic [1:0]   os [2];
  logic         bsy [2];

  logic [33:0]  sb0 [$];
  logic [33:0]  sb1 [$];
  logic [33:0]  mon_e;

  int n_chk = 0;
  int n_fail = 0;
  int re_cnt [2][4];

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) begin
        eb[g][i] = (wp[g][i] != rp[g][i]);
        fd[g][i*32 +: 32] = dout[g][i];
      end
    end
  end

  // FIFO read side: data_out updates on the edge where re is sampled.
  always @(posedge rclk or posedge reset) begin
    if (reset) begin
      for (int g = 0; g < 2; g++)
        for (int i = 0; i < 4; i++) begin
          rp[g][i]   <= wp[g][i];
          dout[g][i] <= '0;
        end
    end else begin
      for (int g = 0; g < 2; g++)
        for (int i = 0; i < 4; i++)
          if (re[g][i]) begin
            dout[g][i] <= mem[g][i][rp[g][i] % 16];
            rp[g][i]   <= rp[g][i] + 1;
          end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    fifo_rd_arbiter #(
      .NUM_REQ(4),
      .DATA_WIDTH(32),
      .BURST_MAX(g == 0 ? 4 : 1)
    ) u_dut (
      .rclk(rclk),
      .reset(reset),
      .fifo_empty_bar(eb[g]),
      .fifo_data(fd[g]),
      .fifo_re(re[g]),
      .out_valid(ov[g]),
      .out_ready(rdy[g]),
      .out_data(od[g]),
      .out_src(os[g]),
      .busy(bsy[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic fput(input int g, input int i, input logic [31:0] d);
    mem[g][i][wp[g][i] % 16] = d;
    wp[g][i]++;
  endtask

  task automatic expect_word(input int g, input int i,
                             input logic [31:0] d);
    if (g == 0) sb0.push_back({2'(i), d});
    else        sb1.push_back({2'(i), d});
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic wait_re(input int g, input int lim);
    int k = 0;
    while (k < lim && re[g] == 4'b0) begin
      @(negedge rclk);
      k++;
    end
    chk("wait_re_timeout", k < lim, 1);
  endtask

  task automatic wait_ov(input int g, input int lim);
    int k = 0;
    while (k < lim && !ov[g]) begin
      @(negedge rclk);
      k++;
    end
    chk("wait_ov_timeout", k < lim, 1);
  endtask

  task automatic drain(input int g, input int lim);
    int k = 0;
    while (k < lim &&
           !(((g == 0) ? sb0.size() : sb1.size()) == 0 && !bsy[g])) begin
      @(negedge rclk);
      k++;
    end
    chk("drain_timeout", k < lim, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d_hold;
    logic [1:0]  s_hold;
    int base, n, bub;

    rdy[0] = 1'b0;
    rdy[1] = 1'b0;

    fork
      forever begin
        @(negedge rclk);
        for (int g = 0; g < 2; g++) begin
          chk("re_onehot", $countones(re[g]) <= 1, 1);
          for (int i = 0; i < 4; i++)
            if (re[g][i]) re_cnt[g][i]++;
          if (!reset && ov[g] && rdy[g]) begin
            if (((g == 0) ? sb0.size() : sb1.size()) == 0) begin
              chk("sb_extra_word", 1, 0);
            end else begin
              mon_e = (g == 0) ? sb0.pop_front() : sb1.pop_front();
              chk("sb_src", os[g], mon_e[33:32]);
              chk("sb_data", od[g], mon_e[31:0]);
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge rclk);
    chk("rst_ov", ov[0], 0);
    chk("rst_re", re[0], 0);
    chk("rst_data", od[0], 0);
    chk("rst_src", os[0], 0);
    chk("rst_busy", bsy[0], 0);
    tick();
    reset = 1'b0;

    // single word from FIFO 2
    rdy[0] = 1'b1;
    tick();
    fput(0, 2, 32'hA5A5_0002);
    expect_word(0, 2, 32'hA5A5_0002);
    wait_re(0, 10);
    chk("single_re", re[0], 4'b0100);
    @(negedge rclk);
    chk("single_load_ov", ov[0], 0);
    chk("single_load_re", re[0], 0);
    @(negedge rclk);
    chk("single_send_ov", ov[0], 1);
    chk("single_data", od[0], 32'hA5A5_0002);
    chk("single_src", os[0], 2);
    @(negedge rclk);
    chk("single_idle_ov", ov[0], 0);
    chk("single_idle_busy", bsy[0], 0);
    chk("single_re_cnt", re_cnt[0][2], 1);

    // burst limit: 6 words in FIFO 0, 2 in FIFO 1
    tick();
    for (int j = 0; j < 6; j++) fput(0, 0, 32'h0000_0100 + j);
    for (int j = 0; j < 2; j++) fput(0, 1, 32'h0000_1100 + j);
    for (int j = 0; j < 4; j++) expect_word(0, 0, 32'h0000_0100 + j);
    for (int j = 0; j < 2; j++) expect_word(0, 1, 32'h0000_1100 + j);
    for (int j = 4; j < 6; j++) expect_word(0, 0, 32'h0000_0100 + j);
    drain(0, 200);

    // round robin on the BURST_MAX=1 instance
    rdy[1] = 1'b1;
    tick();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 2; j++)
        fput(1, i, {8'hB0, 8'(i), 16'(j)});
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 4; i++)
        expect_word(1, i, {8'hB0, 8'(i), 16'(j)});
    drain(1, 300);
    chk("rr_re_cnt0", re_cnt[1][0], 2);
    chk("rr_re_cnt3", re_cnt[1][3], 2);

    // backpressure on FIFO 1
    rdy[0] = 1'b0;
    tick();
    fput(0, 1, 32'h5EED_0001);
    fput(0, 1, 32'h5EED_0002);
    expect_word(0, 1, 32'h5EED_0001);
    expect_word(0, 1, 32'h5EED_0002);
    base = re_cnt[0][1];
    wait_ov(0, 20);
    d_hold = od[0];
    s_hold = os[0];
    chk("bp_first_data", d_hold, 32'h5EED_0001);
    for (int c = 0; c < 10; c++) begin
      @(negedge rclk);
      chk("bp_data", od[0], d_hold);
      chk("bp_src", os[0], s_hold);
      chk("bp_ov", ov[0], 1);
      chk("bp_busy", bsy[0], 1);
      chk("bp_re", re[0], 0);
    end
    tick();
    rdy[0] = 1'b1;
    drain(0, 100);
    chk("bp_re_cnt", re_cnt[0][1] - base, 2);

    // sole requester FIFO 3, 9 words
    tick();
    for (int j = 0; j < 9; j++) fput(0, 3, 32'h3300_0000 + j);
    for (int j = 0; j < 9; j++) expect_word(0, 3, 32'h3300_0000 + j);
    base = re_cnt[0][3];
    wait_re(0, 10);
    chk("sole_re", re[0], 4'b1000);
    n = 0;
    bub = 0;
    for (int c = 0; c < 60 && n < 9; c++) begin
      @(negedge rclk);
      if (ov[0] && rdy[0]) n++;
      else if (!bsy[0]) bub++;
    end
    chk("sole_words", n, 9);
    chk("sole_bubbles", bub, 2);
    drain(0, 50);
    chk("sole_re_cnt", re_cnt[0][3] - base, 9);

    // reset while holding a word in SEND
    rdy[0] = 1'b0;
    tick();
    fput(0, 2, 32'hDEAD_0002);
    expect_word(0, 2, 32'hDEAD_0002);
    wait_ov(0, 20);
    @(posedge rclk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_ov", ov[0], 0);
    chk("mid_rst_re", re[0], 0);
    chk("mid_rst_data", od[0], 0);
    chk("mid_rst_src", os[0], 0);
    chk("mid_rst_busy", bsy[0], 0);
    sb0.delete();
    repeat (2) @(posedge rclk);
    #1 reset = 1'b0;
    rdy[0] = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) fput(0, i, 32'hC000_0000 + i);
    for (int i = 0; i < 4; i++) expect_word(0, i, 32'hC000_0000 + i);
    wait_re(0, 10);
    chk("post_rst_grant", re[0], 4'b0001);
    drain(0, 100);

    chk("sb0_empty", sb0.size(), 0);
    chk("sb1_empty", sb1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
